uart_fifo_tx: RTL

//  Output end of the I/O path. Drains bytes from an output FIFO and serializes each one onto a UART line as 8N1, LSB first.

---
 rtl/io_pkg.sv | 14 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_fifo_tx.sv | 101 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and line-rate defaults for the UART FIFO I/O path
package io_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int DEFAULT_CLK_FREQ = 12_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  // Rounded clock cycles per bit period; the tx and rx sides must agree on it.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter; bit_end_o marks the last cycle of a bit
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNTW         = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_end_o
);

  logic [CNTW-1:0] cnt_q;

  assign bit_end_o = en_i && (cnt_q == CNTW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (bit_end_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - drains an output FIFO onto a UART tx line as 8N1, LSB first
module uart_fifo_tx
  import io_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNTW         = $clog2(CLKS_PER_BIT);

  tx_state_t  state_q;
  logic [2:0] bit_q;
  logic [2:0] bit_d;
  logic [7:0] shift_q;
  logic       tx_q;
  logic       bit_end;
  logic       load;

  // A new byte is taken only when idle or in the very last stop cycle, so frames
  // are never cut short and pops are always a full frame apart.
  assign load     = !rst && !fifo_empty &&
                    (state_q == TX_IDLE || (state_q == TX_STOP && bit_end));
  assign fifo_pop = load;
  assign tx       = tx_q;
  assign busy     = (state_q != TX_IDLE);
  assign bit_d    = bit_q + 3'd1;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNTW        (CNTW)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (load),
    .en_i     (state_q != TX_IDLE),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      tx_q    <= 1'b1;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (load) begin
            shift_q <= fifo_data;
            state_q <= TX_START;
            tx_q    <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state_q <= TX_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_d;
              tx_q  <= shift_q[bit_d];
            end
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (load) begin
              shift_q <= fifo_data;
              state_q <= TX_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
